// File: rtl/p_i_cache_control.sv
// p_i_cache_control -- control stage of the pipelined 4-way instruction cache.
//
// Takes the hit/valid/PLRU/line results of the array check stage, answers the
// CPU fetch (same cycle on a hit), and on a miss runs a single line refill from
// physical memory followed by one re-read cycle so the request then hits.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   mem_read, prev_address           CPU fetch request and its address
//   mem_rdata, mem_resp              fetched word and completion strobe
//   stall, addr_hold                 freeze fetch / hold array address on prev_address
//   hit, way_N_hit                   check-stage hit results (N = 0..3)
//   v_array_N_dataout                valid bits of the indexed set
//   LRU_array_dataout                PLRU word of the indexed set
//   dataout                          256-bit hit line
//   read_array_flag                  array read enable
//   v_array_N_load/_datain           valid-bit write controls
//   tag_array_N_load                 tag write enable
//   LRU_array_load/_datain           PLRU write controls
//   write_en_N_MUX_sel,
//   data_array_N_datain_MUX_sel      data-array write controls
//   pmem_read, pmem_resp             line-fill handshake with physical memory

package p_i_cache_pkg;
  typedef enum logic {
    no_write        = 1'b0,
    mem_write_cache = 1'b1
  } dataarraymux_sel_t;
endpackage

module p_i_cache_control
  import p_i_cache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic [31:0]           prev_address,
  output logic [31:0]           mem_rdata,
  output logic                  mem_resp,
  output logic                  stall,
  output logic                  addr_hold,
  input  logic                  hit,
  input  logic                  way_0_hit,
  input  logic                  way_1_hit,
  input  logic                  way_2_hit,
  input  logic                  way_3_hit,
  input  logic                  v_array_0_dataout,
  input  logic                  v_array_1_dataout,
  input  logic                  v_array_2_dataout,
  input  logic                  v_array_3_dataout,
  input  logic [2:0]            LRU_array_dataout,
  input  logic [(8<<s_offset)-1:0] dataout,
  output logic                  read_array_flag,
  output logic                  v_array_0_load,
  output logic                  v_array_1_load,
  output logic                  v_array_2_load,
  output logic                  v_array_3_load,
  output logic                  v_array_0_datain,
  output logic                  v_array_1_datain,
  output logic                  v_array_2_datain,
  output logic                  v_array_3_datain,
  output logic                  tag_array_0_load,
  output logic                  tag_array_1_load,
  output logic                  tag_array_2_load,
  output logic                  tag_array_3_load,
  output logic                  LRU_array_load,
  output logic [2:0]            LRU_array_datain,
  output dataarraymux_sel_t     write_en_0_MUX_sel,
  output dataarraymux_sel_t     write_en_1_MUX_sel,
  output dataarraymux_sel_t     write_en_2_MUX_sel,
  output dataarraymux_sel_t     write_en_3_MUX_sel,
  output dataarraymux_sel_t     data_array_0_datain_MUX_sel,
  output dataarraymux_sel_t     data_array_1_datain_MUX_sel,
  output dataarraymux_sel_t     data_array_2_datain_MUX_sel,
  output dataarraymux_sel_t     data_array_3_datain_MUX_sel,
  output logic                  pmem_read,
  input  logic                  pmem_resp
);

  // The PLRU tree and port list are hard-wired for four ways.
  if (num_ways != 4 || s_offset + s_index > 32) begin : g_param_check
    $error("p_i_cache_control supports exactly 4 ways and s_offset + s_index <= 32");
  end

  typedef enum logic [1:0] {CHECK, FILL, REREAD} state_t;

  state_t     state;
  logic [1:0] victim;
  logic [1:0] victim_next;
  logic [2:0] lru_next;
  logic [3:0] valid;
  logic [3:0] way_load;
  logic       fill_done;
  logic       req;
  logic [s_offset-3:0] word_sel;

  // Tag and byte-in-word bits are resolved upstream.
  logic unused_addr;
  assign unused_addr = ^{prev_address[31:s_offset], prev_address[1:0]};

  assign valid    = {v_array_3_dataout, v_array_2_dataout, v_array_1_dataout, v_array_0_dataout};
  assign word_sel = prev_address[s_offset-1:2];
  assign mem_rdata = dataout[{word_sel, 5'b00000} +: 32];

  // A request seen while reset is held must not produce a response or a stall.
  assign req = mem_read & ~rst;

  // Victim: first empty way, otherwise follow the PLRU tree.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    victim_next = 2'd0;
    if (!valid[0])                 victim_next = 2'd0;
    else if (!valid[1])            victim_next = 2'd1;
    else if (!valid[2])            victim_next = 2'd2;
    else if (!valid[3])            victim_next = 2'd3;
    else if (!LRU_array_dataout[2]) victim_next = LRU_array_dataout[1] ? 2'd1 : 2'd0;
    else                           victim_next = LRU_array_dataout[0] ? 2'd3 : 2'd2;
  end

  // PLRU update points the tree away from the accessed way; with several hit
  // lines asserted the highest-index way wins.
  always_comb begin
    lru_next = LRU_array_dataout;
    if (way_3_hit) begin
      lru_next[2] = 1'b0;
      lru_next[0] = 1'b0;
    end else if (way_2_hit) begin
      lru_next[2] = 1'b0;
      lru_next[0] = 1'b1;
    end else if (way_1_hit) begin
      lru_next[2] = 1'b1;
      lru_next[1] = 1'b0;
    end else if (way_0_hit) begin
      lru_next[2] = 1'b1;
      lru_next[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state  <= CHECK;
      victim <= 2'd0;
    end else begin
      unique case (state)
        CHECK: begin
          if (req && !hit) begin
            victim <= victim_next;
            state  <= FILL;
          end
        end
        FILL:    if (pmem_resp) state <= REREAD;
        REREAD:  state <= CHECK;
        default: state <= CHECK;
      endcase
    end
  end

  always_comb begin
    mem_resp         = 1'b0;
    stall            = 1'b0;
    addr_hold        = 1'b0;
    read_array_flag  = 1'b1;
    pmem_read        = 1'b0;
    LRU_array_load   = 1'b0;
    LRU_array_datain = 3'b000;
    fill_done        = 1'b0;
    unique case (state)
      CHECK: begin
        if (req) begin
          if (hit) begin
            mem_resp         = 1'b1;
            LRU_array_load   = 1'b1;
            LRU_array_datain = lru_next;
          end else begin
            stall     = 1'b1;
            addr_hold = 1'b1;
          end
        end
      end
      FILL: begin
        pmem_read       = 1'b1;
        stall           = 1'b1;
        addr_hold       = 1'b1;
        read_array_flag = 1'b0;
        fill_done       = pmem_resp;
      end
      REREAD: begin
        stall     = 1'b1;
        addr_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Only the latched victim way is written when the line arrives.
  always_comb begin
    way_load = 4'b0000;
    if (fill_done) way_load[victim] = 1'b1;
  end

  assign v_array_0_load   = way_load[0];
  assign v_array_1_load   = way_load[1];
  assign v_array_2_load   = way_load[2];
  assign v_array_3_load   = way_load[3];
  assign v_array_0_datain = way_load[0];
  assign v_array_1_datain = way_load[1];
  assign v_array_2_datain = way_load[2];
  assign v_array_3_datain = way_load[3];
  assign tag_array_0_load = way_load[0];
  assign tag_array_1_load = way_load[1];
  assign tag_array_2_load = way_load[2];
  assign tag_array_3_load = way_load[3];

  assign write_en_0_MUX_sel = way_load[0] ? mem_write_cache : no_write;
  assign write_en_1_MUX_sel = way_load[1] ? mem_write_cache : no_write;
  assign write_en_2_MUX_sel = way_load[2] ? mem_write_cache : no_write;
  assign write_en_3_MUX_sel = way_load[3] ? mem_write_cache : no_write;
  assign data_array_0_datain_MUX_sel = way_load[0] ? mem_write_cache : no_write;
  assign data_array_1_datain_MUX_sel = way_load[1] ? mem_write_cache : no_write;
  assign data_array_2_datain_MUX_sel = way_load[2] ? mem_write_cache : no_write;
  assign data_array_3_datain_MUX_sel = way_load[3] ? mem_write_cache : no_write;

endmodule

// File: doc/p_i_cache_control.md
Name: p_i_cache_control

Overview:
- Control stage of the pipelined 4-way instruction cache.
- Sits directly downstream of the metadata/data array check stage. Consumes its hit vector, valid bits, 3-bit pseudo-LRU word and 256-bit line.
- Produces the CPU response word and stall, drives the array load/write-enable controls back into that stage, and runs the miss-refill handshake with physical memory.

Parameters:
- s_offset, 5, byte-offset bits per line
- s_index, 3, set-index bits
- num_ways, 4, associativity (block is fixed at 4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  CPU fetch request (registered with prev_address)
- prev_address  in  32  address of the request being checked
- mem_rdata  out  32  fetched instruction word
- mem_resp  out  1  fetch complete
- stall  out  1  freeze fetch stage / address register
- addr_hold  out  1  upstream array-address mux selects prev_address instead of next PC
- hit, way_0_hit..way_3_hit  in  1 each  from check stage
- v_array_0_dataout..v_array_3_dataout  in  1 each  valid bits of indexed set
- LRU_array_dataout  in  3  PLRU bits of indexed set
- dataout  in  256  hit line
- read_array_flag  out  1  array read enable
- v_array_N_load, v_array_N_datain, tag_array_N_load  out  1 each (N=0..3)
- LRU_array_load  out  1
- LRU_array_datain  out  3
- write_en_N_MUX_sel, data_array_N_datain_MUX_sel  out  dataarraymux_sel_t (N=0..3), values no_write / mem_write_cache
- pmem_read  out  1  line-fill request
- pmem_resp  in  1  line returned, pmem_rdata valid this cycle

Behaviour:
- Reset state: CHECK. Outputs at reset:
  - mem_resp=0, stall=0, addr_hold=0, pmem_read=0, read_array_flag=1.
  - All loads 0, all MUX sels no_write, LRU_array_datain=0, victim register=0.
- Reset asserted mid-fill: pmem_read drops immediately (asynchronous) and no array load occurs.
- States: CHECK, FILL, REREAD.
- CHECK, mem_read=0:
  - Idle; read_array_flag=1, stall=0, no loads.
- CHECK, mem_read=1 and hit=1 (zero added latency):
  - Same cycle: mem_resp=1, mem_rdata=dataout[32*prev_address[4:2] +: 32], stall=0.
  - LRU_array_load=1 with updated PLRU word.
- CHECK, mem_read=1 and hit=0:
  - Same cycle: stall=1, addr_hold=1.
  - Latch victim: lowest-index way with valid=0; if all valid, the PLRU victim.
  - Next state FILL.
- PLRU encoding:
  - bit2=0 means the victim is in {0,1}, else {2,3}.
  - bit1 selects way0 (0) or way1 (1).
  - bit0 selects way2 (0) or way3 (1).
- PLRU update on access to way w (untouched bit keeps its old value):
  - w0 → bit2=1, bit1=1
  - w1 → bit2=1, bit1=0
  - w2 → bit2=0, bit0=1
  - w3 → bit2=0, bit0=0
- More than one way_N_hit asserted: the highest-index way is used for the PLRU update.
- FILL:
  - pmem_read=1, stall=1, addr_hold=1, read_array_flag=0.
  - Stay until pmem_resp=1.
  - In the pmem_resp cycle, for the victim way only: write_en and datain sel=mem_write_cache, v_array load=1 with datain=1, tag_array load=1.
  - pmem_read is still high in that cycle. Next state REREAD.
- REREAD:
  - stall=1, addr_hold=1, read_array_flag=1, pmem_read=0.
  - Next state CHECK, where the request hits and completes normally.
  - Miss-to-resp latency is therefore pmem latency + 2 cycles.
- pmem_resp asserted outside FILL: ignored.
- mem_read dropping during FILL: the fill still completes, and the returning CHECK cycle produces no mem_resp.
- Only one outstanding fill; no writes from the CPU side ever occur.

Test Plan:
- Reset with rst pulsed asynchronously between clock edges → all outputs at reset values immediately; state CHECK.
- Cold miss at 0x0000_0040, all valid=0, pmem_resp after 5 cycles:
  - way0 loaded in the resp cycle.
  - mem_resp one cycle after REREAD, returning word 0 of the line.
  - LRU write 3'b110.
- Hit in way2 with LRU=3'b011 and prev_address[4:2]=5 → same-cycle mem_resp, mem_rdata=dataout[191:160], LRU_array_datain=3'b011.
- Full set, all valid, LRU=3'b100, miss → victim way2 (bit2=1, bit0=0) loaded; way0/1/3 loads stay 0.
- rst asserted during FILL while pmem_read=1 → pmem_read=0 at once, no load asserted; a later pmem_resp is ignored.
- Back-to-back hits to ways 0,1,2,3 starting LRU=000 → LRU sequence 110, 100, 001, 000.
